mem_stage: RTL and testbench

Memory-access stage of the pipelined RV32I core, directly downstream of the execute stage. It takes the execute-stage adder result as a load/store effective address, or as a plain result for non-memory ops. It runs the data-bus request/acknowledge handshake, aligns store data and byte enables, and extracts and extends load data. Its output is a single-cycle writeback record, and it back-pressures execute while a bus access is outstanding.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_align.sv | 70 +++++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, funct3 encodings and
// the stage-state enum.
package mem_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store-side byte enables, data replication and fault
// detection; load-side lane selection and sign/zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic            st_load,
    input  logic            st_store,
    input  logic [1:0]      st_addr_lo,
    input  logic [2:0]      st_funct3,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic            fault,
    input  logic [XLEN-1:0] ld_rdata,
    input  logic [1:0]      ld_addr_lo,
    input  logic [2:0]      ld_funct3,
    output logic [XLEN-1:0] ld_value
);

    logic       misaligned;
    logic       illegal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be         = 4'b0000;
        wdata      = st_data;
        misaligned = 1'b0;
        case (st_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                be         = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{st_data[15:0]}};
                misaligned = st_addr_lo[0];
            end
            2'b10: begin
                be         = 4'b1111;
                misaligned = |st_addr_lo;
            end
            default: be = 4'b0000;
        endcase
        // Loads allow the unsigned byte/half forms; stores allow only the low three.
        if (st_load)
            illegal = (st_funct3[1:0] == 2'b11) || (st_funct3 == 3'b110);
        else
            illegal = (st_funct3[1:0] == 2'b11) || st_funct3[2];
        fault = (st_load || st_store) && (illegal || misaligned);
    end

    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_rdata[7:0];
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_value = {24'h0, ld_byte};
            F3_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_value = {16'h0, ld_half};
            default: ld_value = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one instruction from execute, runs a single data-bus
// request/ack access for aligned loads/stores, and emits a one-cycle writeback record.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_r,
    output logic             ex_ready_w,
    input  logic             ex_load_r,
    input  logic             ex_store_r,
    input  logic [2:0]       ex_funct3_r,
    input  logic [XLEN-1:0]  ex_alu_result_r,
    input  logic [XLEN-1:0]  ex_rb_value_r,
    input  logic [REG_W-1:0] ex_rd_r,
    output logic             d_req_w,
    output logic             d_we_w,
    output logic [XLEN-1:0]  d_addr_w,
    output logic [3:0]       d_be_w,
    output logic [XLEN-1:0]  d_wdata_w,
    input  logic             d_ack_r,
    input  logic [XLEN-1:0]  d_rdata_r,
    output logic             wb_valid_r,
    output logic [REG_W-1:0] wb_rd_r,
    output logic [XLEN-1:0]  wb_value_r,
    output logic             wb_exc_r
);

    // Handshake: an instruction transfers on a rising edge where ex_valid_r && ex_ready_w;
    // ex_ready_w is high only in IDLE, and the bus side completes on the edge where
    // d_ack_r is seen while d_req_w is high.
    stage_state_t state, state_next;

    logic             accept;
    logic             is_mem;
    logic             bus_done;
    logic [3:0]       be;
    logic [XLEN-1:0]  wdata;
    logic             fault;
    logic [XLEN-1:0]  ld_value;
    logic             pend_load;
    logic [REG_W-1:0] pend_rd;
    logic [1:0]       pend_addr_lo;
    logic [2:0]       pend_funct3;

    assign ex_ready_w = (state == IDLE);
    assign accept     = ex_valid_r && ex_ready_w;
    assign is_mem     = ex_load_r || ex_store_r;
    assign bus_done   = (state == BUS) && d_ack_r;

    mem_align u_align (
        .st_load    (ex_load_r),
        .st_store   (ex_store_r),
        .st_addr_lo (ex_alu_result_r[1:0]),
        .st_funct3  (ex_funct3_r),
        .st_data    (ex_rb_value_r),
        .be         (be),
        .wdata      (wdata),
        .fault      (fault),
        .ld_rdata   (d_rdata_r),
        .ld_addr_lo (pend_addr_lo),
        .ld_funct3  (pend_funct3),
        .ld_value   (ld_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_mem && !fault) state_next = BUS;
            BUS:     if (d_ack_r) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_req_w      <= 1'b0;
            d_we_w       <= 1'b0;
            d_addr_w     <= '0;
            d_be_w       <= 4'b0000;
            d_wdata_w    <= '0;
            wb_valid_r   <= 1'b0;
            wb_rd_r      <= '0;
            wb_value_r   <= '0;
            wb_exc_r     <= 1'b0;
            pend_load    <= 1'b0;
            pend_rd      <= '0;
            pend_addr_lo <= 2'b00;
            pend_funct3  <= 3'b000;
        end else begin
            wb_valid_r <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    wb_valid_r <= 1'b1;
                    wb_rd_r    <= ex_rd_r;
                    wb_value_r <= ex_alu_result_r;
                    wb_exc_r   <= 1'b0;
                end else if (fault) begin
                    wb_valid_r <= 1'b1;
                    wb_rd_r    <= '0;
                    wb_value_r <= ex_alu_result_r;
                    wb_exc_r   <= 1'b1;
                end else begin
                    d_req_w      <= 1'b1;
                    d_we_w       <= ex_store_r;
                    d_addr_w     <= {ex_alu_result_r[XLEN-1:2], 2'b00};
                    d_be_w       <= be;
                    d_wdata_w    <= wdata;
                    pend_load    <= ex_load_r;
                    pend_rd      <= ex_rd_r;
                    pend_addr_lo <= ex_alu_result_r[1:0];
                    pend_funct3  <= ex_funct3_r;
                end
            end
            if (bus_done) begin
                d_req_w    <= 1'b0;
                wb_valid_r <= 1'b1;
                wb_exc_r   <= 1'b0;
                wb_rd_r    <= pend_load ? pend_rd : '0;
                wb_value_r <= pend_load ? ld_value : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a driver issues instructions and plays the bus slave,
// pushing the expected writeback record; a monitor pops and compares on each wb pulse.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_r;
    logic        ex_ready_w;
    logic        ex_load_r;
    logic        ex_store_r;
    logic [2:0]  ex_funct3_r;
    logic [31:0] ex_alu_result_r;
    logic [31:0] ex_rb_value_r;
    logic [4:0]  ex_rd_r;
    logic        d_req_w;
    logic        d_we_w;
    logic [31:0] d_addr_w;
    logic [3:0]  d_be_w;
    logic [31:0] d_wdata_w;
    logic        d_ack_r;
    logic [31:0] d_rdata_r;
    logic        wb_valid_r;
    logic [4:0]  wb_rd_r;
    logic [31:0] wb_value_r;
    logic        wb_exc_r;

    // Expected writeback record: {exc, rd, value}
    logic [37:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid_r      (ex_valid_r),
        .ex_ready_w      (ex_ready_w),
        .ex_load_r       (ex_load_r),
        .ex_store_r      (ex_store_r),
        .ex_funct3_r     (ex_funct3_r),
        .ex_alu_result_r (ex_alu_result_r),
        .ex_rb_value_r   (ex_rb_value_r),
        .ex_rd_r         (ex_rd_r),
        .d_req_w         (d_req_w),
        .d_we_w          (d_we_w),
        .d_addr_w        (d_addr_w),
        .d_be_w          (d_be_w),
        .d_wdata_w       (d_wdata_w),
        .d_ack_r         (d_ack_r),
        .d_rdata_r       (d_rdata_r),
        .wb_valid_r      (wb_valid_r),
        .wb_rd_r         (wb_rd_r),
        .wb_value_r      (wb_value_r),
        .wb_exc_r        (wb_exc_r)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every wb pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && wb_valid_r) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {wb_exc_r, wb_rd_r, wb_value_r}, 38'h3f_ffff_ffff);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                chk("wb_record", {wb_exc_r, wb_rd_r, wb_value_r}, e);
            end
        end
    end

    // Driver tasks
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        @(negedge clk);
        chk("ex_ready_before_issue", {37'h0, ex_ready_w}, 38'h1);
        ex_valid_r      = 1'b1;
        ex_load_r       = ld;
        ex_store_r      = st;
        ex_funct3_r     = f3;
        ex_alu_result_r = addr;
        ex_rb_value_r   = data;
        ex_rd_r         = rd;
        @(posedge clk);
        #1;
        ex_valid_r = 1'b0;
        ex_load_r  = 1'b0;
        ex_store_r = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] result, input logic [4:0] rd);
        exp_q.push_back({1'b0, rd, result});
        issue(1'b0, 1'b0, 3'b000, result, 32'h0, rd);
    endtask

    task automatic exc_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [4:0] rd);
        exp_q.push_back({1'b1, 5'd0, addr});
        issue(ld, st, f3, addr, 32'h5555_5555, rd);
        @(negedge clk);
        chk("exc_no_req", {37'h0, d_req_w}, 38'h0);
    endtask

    // Issue an aligned access, act as bus slave acking after `delay` request cycles
    task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input int delay,
                          input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_value);
        exp_q.push_back({1'b0, ld ? rd : 5'd0, ld ? exp_value : 32'h0});
        issue(ld, !ld, f3, addr, data, rd);
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            chk("d_req_held", {37'h0, d_req_w}, 38'h1);
            chk("ex_ready_low", {37'h0, ex_ready_w}, 38'h0);
            chk("d_we", {37'h0, d_we_w}, {37'h0, !ld});
            chk("d_addr", {6'h0, d_addr_w}, {6'h0, addr[31:2], 2'b00});
            chk("d_be", {34'h0, d_be_w}, {34'h0, exp_be});
            if (!ld) chk("d_wdata", {6'h0, d_wdata_w}, {6'h0, exp_wdata});
            if (k == delay) begin
                d_ack_r   = 1'b1;
                d_rdata_r = rdata;
            end else begin
                d_rdata_r = 32'h0BAD_F00D;
            end
            @(posedge clk);
            #1;
            d_ack_r = 1'b0;
        end
        @(negedge clk);
        chk("ready_after_ack", {36'h0, ex_ready_w, d_req_w}, 38'h2);
    endtask

    initial begin
        ex_valid_r = 0; ex_load_r = 0; ex_store_r = 0; ex_funct3_r = 0;
        ex_alu_result_r = 0; ex_rb_value_r = 0; ex_rd_r = 0;
        d_ack_r = 0; d_rdata_r = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {37'h0, ex_ready_w}, 38'h1);
        chk("reset_bus", {d_req_w, d_we_w, d_be_w, d_addr_w}, 38'h0);
        chk("reset_wdata", {6'h0, d_wdata_w}, 38'h0);
        chk("reset_wb", {wb_valid_r, wb_exc_r, wb_rd_r, wb_value_r[30:0]}, 38'h0);
        rst_n = 1'b1;

        // Non-memory ops, back to back
        alu_op(32'h0000_1234, 5'd5);
        chk("alu_no_req", {37'h0, d_req_w}, 38'h0);
        alu_op(32'hCAFE_0001, 5'd31);
        alu_op(32'h0000_0000, 5'd1);

        // Stores
        mem_op(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd7, 3, 32'h0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        mem_op(1'b0, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd2, 1, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        mem_op(1'b0, 3'b000, 32'h0000_0001, 32'h1234_56A5, 5'd2, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);

        // Loads
        mem_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd10, 0, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
        mem_op(1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd11, 0, 32'h80FF_0000, 4'b1000, 32'h0, 32'h0000_0080);
        mem_op(1'b1, 3'b101, 32'h0000_0202, 32'h0, 5'd4, 2, 32'h8001_7FFF, 4'b1100, 32'h0, 32'h0000_8001);
        mem_op(1'b1, 3'b001, 32'h0000_0202, 32'h0, 5'd4, 0, 32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001);
        mem_op(1'b1, 3'b001, 32'h0000_0100, 32'h0, 5'd6, 1, 32'h0000_8000, 4'b0011, 32'h0, 32'hFFFF_8000);
        mem_op(1'b1, 3'b000, 32'h0000_0100, 32'h0, 5'd8, 0, 32'h0000_007F, 4'b0001, 32'h0, 32'h0000_007F);
        mem_op(1'b1, 3'b010, 32'h0000_0304, 32'h0, 5'd9, 0, 32'h1234_5678, 4'b1111, 32'h0, 32'h1234_5678);

        // Misaligned and illegal accesses
        exc_op(1'b1, 1'b0, 3'b001, 32'h0000_0101, 5'd3);
        exc_op(1'b0, 1'b1, 3'b010, 32'h0000_0102, 5'd3);
        exc_op(1'b0, 1'b1, 3'b011, 32'h0000_0100, 5'd3);
        exc_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, 5'd3);
        exc_op(1'b0, 1'b1, 3'b100, 32'h0000_0100, 5'd3);
        alu_op(32'h0000_0042, 5'd12);

        // Reset in the middle of an outstanding access
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd13);
        @(negedge clk);
        chk("abort_req_before", {37'h0, d_req_w}, 38'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_req_async", {36'h0, d_req_w, wb_valid_r}, 38'h0);
        chk("abort_ready", {37'h0, ex_ready_w}, 38'h1);
        @(negedge clk);
        rst_n = 1'b1;
        d_ack_r = 1'b1;
        d_rdata_r = 32'h7777_7777;
        repeat (2) @(posedge clk);
        #1;
        d_ack_r = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_idle", {36'h0, ex_ready_w, d_req_w}, 38'h2);
        alu_op(32'h0000_0099, 5'd14);

        repeat (3) @(negedge clk);
        chk("queue_drained", {6'h0, 32'(exp_q.size())}, 38'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
